// File: rtl/serial_sum_ctrl.sv
// serial_sum_ctrl: sums a masked set of NUM_OPS signed operand beats through one shared adder,
// publishing a registered sum with a one-cycle done pulse.
module serial_sum_ctrl #(
    parameter int DATAW   = 8,
    parameter int SUMW    = 32,
    parameter int NUM_OPS = 16,
    parameter int CNTW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NUM_OPS-1:0] mask,
    input  logic               op_valid,
    input  logic [DATAW-1:0]   op_data,
    output logic               op_ready,
    output logic [CNTW-1:0]    op_index,
    output logic               busy,
    output logic               done,
    output logic [SUMW-1:0]    sum,
    output logic               overflow
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state_q, state_d;
    logic [SUMW-1:0] acc_q, acc_d, sum_q, sum_d, ext, add;
    logic [CNTW-1:0] idx_q, idx_d;
    logic [NUM_OPS-1:0] mask_q, mask_d, mask_sh;
    logic busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, last;

    always_comb begin
        ext = SUMW'($signed(op_data));
        add = acc_q + ext;
        mask_sh = mask_q >> idx_q;
        last = idx_q == CNTW'(NUM_OPS - 1);
        state_d = state_q;
        acc_d = acc_q;
        sum_d = sum_q;
        idx_d = idx_q;
        mask_d = mask_q;
        ovf_d = ovf_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = ACCUM;
                mask_d = mask;
                acc_d = '0;
                idx_d = '0;
                ovf_d = 1'b0;
            end
            ACCUM: if (op_valid) begin
                if (mask_sh[0]) begin
                    acc_d = add;
                    ovf_d = ovf_q | (acc_q[SUMW-1] == ext[SUMW-1] && add[SUMW-1] != acc_q[SUMW-1]);
                end
                idx_d = last ? idx_q : idx_q + CNTW'(1);
                if (last) begin
                    state_d = DONE;
                    done_d = 1'b1;
                    sum_d = acc_d;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q <= '0;
            sum_q <= '0;
            idx_q <= '0;
            mask_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            sum_q <= sum_d;
            idx_q <= idx_d;
            mask_q <= mask_d;
            busy_q <= busy_d;
            done_q <= done_d;
            ovf_q <= ovf_d;
        end
    end

    assign op_ready = state_q == ACCUM;
    assign op_index = idx_q;
    assign busy = busy_q;
    assign done = done_q;
    assign sum = sum_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_sum_ctrl.sv
// tb_serial_sum_ctrl: table-driven runs on the default configuration plus hand sequences
// for 8-bit overflow and asynchronous reset mid-run.
module tb_serial_sum_ctrl;
    logic clk = 0, rst = 0, start = 0, op_valid = 0;
    logic [15:0] mask = '0;
    logic [7:0] op_data = '0;
    logic op_ready, busy, done, overflow;
    logic [7:0] op_index;
    logic [31:0] sum;

    logic s_start = 0, s_valid = 0;
    logic [1:0] s_mask = '0;
    logic [7:0] s_data = '0, s_index, s_sum;
    logic s_ready, s_busy, s_done, s_ovf;

    int total = 0, bad = 0, cyc_cnt = 0;

    serial_sum_ctrl dut (.clk(clk), .rst(rst), .start(start), .mask(mask), .op_valid(op_valid),
        .op_data(op_data), .op_ready(op_ready), .op_index(op_index), .busy(busy), .done(done),
        .sum(sum), .overflow(overflow));

    serial_sum_ctrl #(.DATAW(8), .SUMW(8), .NUM_OPS(2), .CNTW(8)) dut8 (.clk(clk), .rst(rst),
        .start(s_start), .mask(s_mask), .op_valid(s_valid), .op_data(s_data), .op_ready(s_ready),
        .op_index(s_index), .busy(s_busy), .done(s_done), .sum(s_sum), .overflow(s_ovf));

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    typedef struct {
        logic [15:0] m;
        logic [7:0]  base;
        int          incr;
        bit          gap;
        bit          hz;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic run16(input vec_t v, output int dcyc);
        int hs = 0, cyc = 0, idx_bad = 0;
        bit seen = 0;
        @(negedge clk);
        start = 1;
        mask = v.m;
        @(negedge clk);
        mask = ~v.m;
        while (!seen && cyc < 200) begin
            if (op_ready) begin
                if (op_index !== 8'(hs)) idx_bad++;
                op_valid = !(v.gap && cyc % 3 == 2);
                op_data = 8'(int'(v.base) + v.incr * hs);
                if (op_valid) hs++;
            end else op_valid = 0;
            start = v.hz && cyc % 4 == 1;
            @(negedge clk);
            cyc++;
            seen = done;
        end
        dcyc = cyc_cnt;
        chk("finished", 32'(seen), 1);
        chk("sum", sum, v.exp);
        chk("ovf", 32'(overflow), 0);
        chk("beats", hs, 16);
        chk("idx_seq", idx_bad, 0);
        chk("idx_done", 32'(op_index), 15);
        chk("busy_done", {busy, op_ready}, 2'b10);
        start = v.hz;
        op_valid = 0;
        @(negedge clk);
        start = 0;
        chk("done_pulse", {done, busy, op_ready}, 3'b000);
        chk("sum_hold", sum, v.exp);
    endtask

    initial begin
        int prev, cur, dn;
        tbl[0] = '{16'hFFFF, 8'd1,   1, 1, 0, 32'd136};
        tbl[1] = '{16'hFFFF, 8'h80,  0, 0, 0, 32'hFFFFF800};
        tbl[2] = '{16'hFFFF, 8'hFF,  0, 0, 0, 32'hFFFFFFF0};
        tbl[3] = '{16'hFBFF, 8'd10,  0, 0, 0, 32'd150};
        tbl[4] = '{16'hFFFF, 8'd1,   1, 0, 1, 32'd136};
        tbl[5] = '{16'h0000, 8'd5,   1, 0, 0, 32'd0};
        tbl[6] = '{16'h5555, 8'd1,   1, 0, 0, 32'd64};

        repeat (2) @(negedge clk);
        chk("rst_sum", sum, 0);
        chk("rst_ctl", {done, busy, op_ready, overflow}, 4'b0000);
        chk("rst_idx", 32'(op_index), 0);
        rst = 1;

        prev = 0;
        for (int i = 0; i < 7; i++) begin
            run16(tbl[i], cur);
            if (i > 0) chk("done_gap", 32'(cur - prev >= 18), 1);
            prev = cur;
        end

        @(negedge clk);
        s_start = 1;
        s_mask = 2'b11;
        @(negedge clk);
        s_start = 0;
        s_valid = 1;
        s_data = 8'h7F;
        @(negedge clk);
        s_data = 8'h01;
        @(negedge clk);
        s_valid = 0;
        chk("ov_run1", {s_done, s_sum, s_ovf}, {1'b1, 8'h80, 1'b1});
        @(negedge clk);
        s_start = 1;
        @(negedge clk);
        s_start = 0;
        s_valid = 1;
        s_data = 8'h01;
        chk("ov_hold", {s_sum, s_ovf}, {8'h80, 1'b0});
        @(negedge clk);
        @(negedge clk);
        s_valid = 0;
        chk("ov_run2", {s_done, s_sum, s_ovf}, {1'b1, 8'h02, 1'b0});

        @(negedge clk);
        start = 1;
        mask = 16'hFFFF;
        @(negedge clk);
        start = 0;
        op_valid = 1;
        op_data = 8'd1;
        repeat (8) @(negedge clk);
        chk("pre_rst_idx", 32'(op_index), 8);
        #2 rst = 0;
        #1;
        chk("arst_sum", sum, 0);
        chk("arst_ctl", {done, busy, op_ready, overflow}, 4'b0000);
        chk("arst_idx", 32'(op_index), 0);
        @(negedge clk);
        rst = 1;
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dn++;
        end
        op_valid = 0;
        chk("arst_nodone", dn, 0);
        chk("arst_sum_hold", sum, 0);
        run16(tbl[4], cur);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
